// File: rtl/systolic_pkg.sv
// Shared types and sizing for the systolic array operand feeder.
package systolic_pkg;

   localparam int unsigned DATA_WIDTH = 16;
   localparam int unsigned N          = 4;
   localparam int unsigned K_MAX      = 16;
   localparam int unsigned K_W        = $clog2(K_MAX + 1);
   localparam int unsigned FLUSH_W    = (N > 1) ? $clog2(N) : 1;

   typedef logic signed [DATA_WIDTH-1:0] lane_t;
   typedef lane_t [N-1:0]                edge_t;
   typedef logic [K_W-1:0]               count_t;
   typedef logic [FLUSH_W-1:0]           flush_t;

   typedef enum logic [1:0] {IDLE, FEED, FLUSH} feeder_state_e;

   function automatic count_t clamp_k(count_t k);
      return (k > count_t'(K_MAX)) ? count_t'(K_MAX) : k;
   endfunction

endpackage

// File: rtl/systolic_operand_feeder_if.sv
// Operand beat handshake plus skewed edge outputs of the feeder.
interface systolic_operand_feeder_if;
   import systolic_pkg::*;

   logic           start;
   count_t         k_len;
   logic           in_valid;
   logic           in_ready;
   edge_t          in_a;
   edge_t          in_b;
   edge_t          a_edge;
   edge_t          b_edge;
   logic [N-1:0]   edge_valid;
   logic           busy;
   logic           done;

   modport master (
      output start, k_len, in_valid, in_a, in_b,
      input  in_ready, a_edge, b_edge, edge_valid, busy, done
   );

   modport slave (
      input  start, k_len, in_valid, in_a, in_b,
      output in_ready, a_edge, b_edge, edge_valid, busy, done
   );

endinterface

// File: rtl/skew_delay_line.sv
// DEPTH-stage shift register carrying data plus a valid bit; advances only when shift is high.
module skew_delay_line #(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned W     = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         shift,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic [W-1:0] out_data,
   output logic         out_valid
);

   logic [DEPTH-1:0][W-1:0] data_q;
   logic [DEPTH-1:0]        valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= '0;
      end else if (shift) begin
         data_q[0]  <= in_data;
         valid_q[0] <= in_valid;
         for (int s = 1; s < int'(DEPTH); s++) begin
            data_q[s]  <= data_q[s-1];
            valid_q[s] <= valid_q[s-1];
         end
      end
   end

   assign out_data  = data_q[DEPTH-1];
   assign out_valid = valid_q[DEPTH-1];

endmodule

// File: rtl/systolic_operand_feeder.sv
// Feeds K operand beats into the 4x4 systolic array with triangular lane skew and zero fill.
module systolic_operand_feeder
   import systolic_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   systolic_operand_feeder_if.slave bus
);

   feeder_state_e state_q;
   count_t        beats_left_q;
   flush_t        flush_q;
   logic          done_q;

   logic          accept;
   logic          shift;
   logic [N-1:0]  a_valid;
   logic [N-1:0]  b_valid;

   assign bus.in_ready   = (state_q == FEED) && (beats_left_q != '0);
   assign accept         = bus.in_ready && bus.in_valid;
   assign shift          = (state_q != IDLE);
   assign bus.busy       = shift;
   assign bus.done       = done_q;
   assign bus.edge_valid = a_valid & b_valid;

   // FLUSH spans N cycles so the last beat is visible on lane N-1 before done rises.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         beats_left_q <= '0;
         flush_q      <= '0;
         done_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  if (bus.k_len == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     beats_left_q <= clamp_k(bus.k_len);
                     state_q      <= FEED;
                  end
               end
            end
            FEED: begin
               if (accept) begin
                  beats_left_q <= beats_left_q - 1'b1;
                  if (beats_left_q == count_t'(1)) begin
                     flush_q <= '0;
                     state_q <= FLUSH;
                  end
               end
            end
            FLUSH: begin
               if (flush_q == flush_t'(N - 1)) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
               end else begin
                  flush_q <= flush_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_lane
      lane_t a_in;
      lane_t b_in;

      // Bubbles and flush cycles inject zeros so partial sums stay aligned.
      assign a_in = accept ? bus.in_a[i] : '0;
      assign b_in = accept ? bus.in_b[i] : '0;

      skew_delay_line #(
         .DEPTH (i + 1),
         .W     (DATA_WIDTH)
      ) u_a_line (
         .clk       (clk),
         .rst_n     (rst_n),
         .shift     (shift),
         .in_data   (a_in),
         .in_valid  (accept),
         .out_data  (bus.a_edge[i]),
         .out_valid (a_valid[i])
      );

      skew_delay_line #(
         .DEPTH (i + 1),
         .W     (DATA_WIDTH)
      ) u_b_line (
         .clk       (clk),
         .rst_n     (rst_n),
         .shift     (shift),
         .in_data   (b_in),
         .in_valid  (accept),
         .out_data  (bus.b_edge[i]),
         .out_valid (b_valid[i])
      );
   end

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Directed bench for systolic_operand_feeder with a per-lane expected-output scoreboard.
module tb_systolic_operand_feeder;
   import systolic_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   systolic_operand_feeder_if bus ();

   systolic_operand_feeder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int    cyc;
      int    lane;
      lane_t a;
      lane_t b;
   } sb_t;

   sb_t  sb[$];
   int   edge_n = 0;
   int   n_chk  = 0;
   int   n_fail = 0;
   logic exp_busy  = 1'b0;
   logic exp_ready = 1'b0;
   logic exp_done  = 1'b0;

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_chk++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, edge_n, obs, expv);
      end
   endtask

   task automatic check_outputs();
      edge_t        ea = '0;
      edge_t        eb = '0;
      logic [N-1:0] ev = '0;
      for (int j = sb.size() - 1; j >= 0; j--) begin
         if (sb[j].cyc == edge_n) begin
            ea[sb[j].lane] = sb[j].a;
            eb[sb[j].lane] = sb[j].b;
            ev[sb[j].lane] = 1'b1;
            sb.delete(j);
         end
      end
      chk("a_edge",     64'(bus.a_edge),     64'(ea));
      chk("b_edge",     64'(bus.b_edge),     64'(eb));
      chk("edge_valid", 64'(bus.edge_valid), 64'(ev));
      chk("busy",       64'(bus.busy),       64'(exp_busy));
      chk("in_ready",   64'(bus.in_ready),   64'(exp_ready));
      chk("done",       64'(bus.done),       64'(exp_done));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic idle_inputs();
      bus.start    = 1'b0;
      bus.k_len    = '0;
      bus.in_valid = 1'b0;
      bus.in_a     = '0;
      bus.in_b     = '0;
   endtask

   // Drives one beat; expected lane i copy appears i edges after the accepting edge.
   task automatic drive_beat(input bit fixed);
      lane_t va;
      lane_t vb;
      bus.in_valid = 1'b1;
      for (int i = 0; i < int'(N); i++) begin
         va = fixed ? lane_t'(i + 1) : lane_t'($urandom);
         vb = fixed ? lane_t'(i + 5) : lane_t'($urandom);
         bus.in_a[i] = va;
         bus.in_b[i] = vb;
         sb.push_back('{edge_n + 1 + i, i, va, vb});
      end
   endtask

   task automatic run_job(input int k, input logic [63:0] pat, input bit fixed, input bit noise);
      int kk;
      int acc;
      int last;
      kk   = (k > int'(K_MAX)) ? int'(K_MAX) : k;
      acc  = 0;
      last = 0;
      bus.start = 1'b1;
      bus.k_len = count_t'(k);
      if (kk == 0) begin
         exp_busy = 1'b0; exp_ready = 1'b0; exp_done = 1'b1;
         step();
         idle_inputs();
         exp_done = 1'b0;
         step();
         step();
         return;
      end
      exp_busy = 1'b1; exp_ready = 1'b1; exp_done = 1'b0;
      step();
      for (int p = 0; p < 64 && acc < kk; p++) begin
         idle_inputs();
         if (noise && p == 1) begin
            bus.start = 1'b1;
            bus.k_len = count_t'(2);
         end
         if (pat[p]) begin
            drive_beat(fixed);
            acc++;
            if (acc == kk) last = edge_n + 1;
         end
         exp_ready = (acc < kk);
         step();
      end
      for (int c = 0; c < int'(N); c++) begin
         idle_inputs();
         if (noise && c == 1) begin
            bus.start = 1'b1;
            bus.k_len = count_t'(1);
         end
         exp_ready = 1'b0;
         exp_busy  = (edge_n + 1 < last + int'(N));
         exp_done  = (edge_n + 1 == last + int'(N));
         step();
      end
      idle_inputs();
      exp_busy = 1'b0; exp_ready = 1'b0; exp_done = 1'b0;
      step();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      step();
      step();
      rst_n = 1'b1;
      step();

      run_job(1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
      run_job(4, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
      run_job(3, 64'b11001, 1'b0, 1'b0);
      run_job(0, 64'h0, 1'b0, 1'b0);

      // Reset in the middle of FEED after two accepted beats.
      bus.start = 1'b1;
      bus.k_len = count_t'(4);
      exp_busy = 1'b1; exp_ready = 1'b1; exp_done = 1'b0;
      step();
      for (int p = 0; p < 2; p++) begin
         idle_inputs();
         drive_beat(1'b0);
         step();
      end
      idle_inputs();
      rst_n = 1'b0;
      #1;
      sb.delete();
      exp_busy = 1'b0; exp_ready = 1'b0; exp_done = 1'b0;
      check_outputs();
      step();
      rst_n = 1'b1;
      step();
      step();

      run_job(2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
      run_job(4, 64'b1101101, 1'b0, 1'b1);
      run_job(20, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
